// File: rtl/pa_lsu_sram_arb_pkg.sv
// pa_lsu_sram_arb_pkg: state encoding and byte-enable to bit-mask helper shared by the LSU SRAM wrappers.
package pa_lsu_sram_arb_pkg;
  typedef enum logic {ST_INIT, ST_RUN} state_e;
  localparam int LSU_SRAM_DW = 32;
  localparam int LSU_SRAM_BE = LSU_SRAM_DW / 8;
  function automatic logic [LSU_SRAM_DW-1:0] be_to_wen(input logic [LSU_SRAM_BE-1:0] be);
    logic [LSU_SRAM_DW-1:0] wen;
    for (int k = 0; k < LSU_SRAM_BE; k++) wen[8*k +: 8] = {8{~be[k]}};
    return wen;
  endfunction
endpackage

// File: rtl/pa_lsu_sram_init_seq.sv
// pa_lsu_sram_init_seq: post-reset zero-fill sweep counter; raises init_done once every entry is written.
module pa_lsu_sram_init_seq
  import pa_lsu_sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] init_addr
);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  done_q, done_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) begin
        state_d = ST_RUN;
        done_d  = 1'b1;
      end
    end
  end
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end
  assign init_done = done_q;
  assign init_addr = cnt_q;
endmodule

// File: rtl/pa_lsu_sram_arb.sv
// pa_lsu_sram_arb: two-port arbiter for the shared LSU SRAM macro with port-1 anti-starvation,
// post-reset zero-fill and per-port read-valid return.
module pa_lsu_sram_arb
  import pa_lsu_sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32,
  parameter int STARVE_MAX = 7,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                    forever_cpuclk,
  input  logic                    cpurst_b,
  input  logic                    p0_req,
  input  logic                    p0_wr,
  input  logic [ADDR_WIDTH-1:0]   p0_addr,
  input  logic [DATA_WIDTH-1:0]   p0_wdata,
  input  logic [DATA_WIDTH/8-1:0] p0_be,
  output logic                    p0_gnt,
  output logic                    p0_rvld,
  output logic [DATA_WIDTH-1:0]   p0_rdata,
  input  logic                    p1_req,
  input  logic                    p1_wr,
  input  logic [ADDR_WIDTH-1:0]   p1_addr,
  input  logic [DATA_WIDTH-1:0]   p1_wdata,
  input  logic [DATA_WIDTH/8-1:0] p1_be,
  output logic                    p1_gnt,
  output logic                    p1_rvld,
  output logic [DATA_WIDTH-1:0]   p1_rdata,
  output logic                    init_done,
  output logic [ADDR_WIDTH-1:0]   sram_a,
  output logic                    sram_cen,
  output logic                    sram_gwen,
  output logic [DATA_WIDTH-1:0]   sram_wen,
  output logic [DATA_WIDTH-1:0]   sram_d,
  input  logic [DATA_WIDTH-1:0]   sram_q
);
  localparam logic [CNT_WIDTH-1:0] STARVE_TOP = CNT_WIDTH'(STARVE_MAX);
  logic [ADDR_WIDTH-1:0]   init_addr;
  logic [CNT_WIDTH-1:0]    starve_q, starve_d;
  logic                    p0_rvld_q, p0_rvld_d, p1_rvld_q, p1_rvld_d;
  logic                    run, any_gnt, wr_sel;
  logic [DATA_WIDTH/8-1:0] be_sel;
  pa_lsu_sram_init_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_init_seq (
    .forever_cpuclk(forever_cpuclk),
    .cpurst_b      (cpurst_b),
    .init_done     (init_done),
    .init_addr     (init_addr)
  );
  always_comb begin
    run       = init_done & cpurst_b;
    p1_gnt    = run & p1_req & (~p0_req | (starve_q == STARVE_TOP));
    p0_gnt    = run & p0_req & ~p1_gnt;
    any_gnt   = p0_gnt | p1_gnt;
    starve_d  = (~p1_req | p1_gnt) ? '0 : (starve_q == STARVE_TOP) ? starve_q : starve_q + 1'b1;
    p0_rvld_d = p0_gnt & ~p0_wr;
    p1_rvld_d = p1_gnt & ~p1_wr;
    wr_sel    = p1_gnt ? p1_wr : p0_wr;
    be_sel    = p1_gnt ? p1_be : p0_be;
    // Before init_done the macro is owned by the zero-fill sweep.
    sram_a    = !init_done ? init_addr : p1_gnt ? p1_addr : p0_addr;
    sram_d    = !init_done ? '0 : p1_gnt ? p1_wdata : p0_wdata;
    sram_cen  = ~cpurst_b | (init_done & ~any_gnt);
    sram_gwen = init_done & ~(any_gnt & wr_sel);
    sram_wen  = !init_done ? '0 : (any_gnt & wr_sel) ? be_to_wen(be_sel) : '1;
  end
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      starve_q  <= '0;
      p0_rvld_q <= 1'b0;
      p1_rvld_q <= 1'b0;
    end else begin
      starve_q  <= starve_d;
      p0_rvld_q <= p0_rvld_d;
      p1_rvld_q <= p1_rvld_d;
    end
  end
  assign p0_rvld  = p0_rvld_q;
  assign p1_rvld  = p1_rvld_q;
  assign p0_rdata = sram_q;
  assign p1_rdata = sram_q;
endmodule

// File: tb/tb_pa_lsu_sram_arb.sv
// tb_pa_lsu_sram_arb: scoreboard bench with a behavioural SRAM macro and an independent reference memory.
module tb_pa_lsu_sram_arb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_wr, p1_req, p1_wr;
  logic [6:0]  p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic [3:0]  p0_be, p1_be;
  logic        p0_gnt, p0_rvld, p1_gnt, p1_rvld, init_done;
  logic [31:0] p0_rdata, p1_rdata;
  logic [6:0]  sram_a;
  logic        sram_cen, sram_gwen;
  logic [31:0] sram_wen, sram_d, sram_q;
  logic [31:0] mem [128];
  logic [31:0] ref_mem [128];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  int          total = 0, bad = 0;
  logic        m_wr;
  logic [6:0]  m_a;
  logic [31:0] m_d;
  logic [3:0]  m_be;

  always #5 clk = ~clk;

  pa_lsu_sram_arb dut (
    .forever_cpuclk(clk), .cpurst_b(rst_n),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
    .p0_gnt(p0_gnt), .p0_rvld(p0_rvld), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
    .p1_gnt(p1_gnt), .p1_rvld(p1_rvld), .p1_rdata(p1_rdata),
    .init_done(init_done), .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
    .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q)
  );

  // Behavioural single-port macro: masked write, registered read.
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else sram_q <= mem[sram_a];
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wen_of(input logic wr, input logic [3:0] be);
    logic [31:0] w;
    w = '1;
    if (wr) for (int k = 0; k < 4; k++) if (be[k]) w[8*k +: 8] = 8'h00;
    return w;
  endfunction

  // Monitor: read-data scoreboard, macro drive on every grant, idle drive in RUN.
  always @(negedge clk) begin
    if (p0_rvld) begin
      if (q0.size() == 0) chk("p0_rvld_unexp", p0_rvld, 1'b0);
      else chk("p0_rdata", p0_rdata, q0.pop_front());
    end
    if (p1_rvld) begin
      if (q1.size() == 0) chk("p1_rvld_unexp", p1_rvld, 1'b0);
      else chk("p1_rdata", p1_rdata, q1.pop_front());
    end
    if (p0_gnt && p1_gnt) chk("gnt_both", {p1_gnt, p0_gnt}, 2'b01);
    if (rst_n && init_done) begin
      if (p0_gnt || p1_gnt) begin
        m_wr = p1_gnt ? p1_wr : p0_wr;
        m_a  = p1_gnt ? p1_addr : p0_addr;
        m_d  = p1_gnt ? p1_wdata : p0_wdata;
        m_be = p1_gnt ? p1_be : p0_be;
        chk("drive", {sram_cen, sram_gwen, sram_a, sram_d, sram_wen},
            {1'b0, ~m_wr, m_a, m_d, wen_of(m_wr, m_be)});
        if (m_wr) begin
          for (int k = 0; k < 4; k++) if (m_be[k]) ref_mem[m_a][8*k +: 8] = m_d[8*k +: 8];
        end else if (p1_gnt) q1.push_back(ref_mem[m_a]);
        else q0.push_back(ref_mem[m_a]);
      end else chk("idle", {sram_cen, sram_gwen, sram_wen}, {2'b11, 32'hFFFF_FFFF});
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    for (int i = 0; i < 128; i++) ref_mem[i] = '0;
    #1 chk("rst_state", {init_done, p0_rvld, p1_rvld, p0_gnt, p1_gnt, sram_cen}, 6'b000001);
  endtask

  task automatic sweep(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("sweep", {init_done, p0_gnt, p1_gnt, sram_cen, sram_gwen, sram_wen, sram_d, sram_a},
          {5'b00000, 32'h0, 32'h0, 7'(i)});
    end
  endtask

  task automatic acc(input logic port, input logic wr, input logic [6:0] a,
                     input logic [31:0] d, input logic [3:0] be);
    int w;
    if (port) begin
      p1_req = 1'b1; p1_wr = wr; p1_addr = a; p1_wdata = d; p1_be = be;
    end else begin
      p0_req = 1'b1; p0_wr = wr; p0_addr = a; p0_wdata = d; p0_be = be;
    end
    for (w = 0; w < 100; w++) begin
      @(negedge clk);
      if (port ? p1_gnt : p0_gnt) break;
    end
    if (w == 100) chk("acc_gnt_timeout", port ? p1_gnt : p0_gnt, 1'b1);
    @(posedge clk);
    #1;
    if (port) p1_req = 1'b0; else p0_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    {p0_req, p0_wr, p0_addr, p0_wdata, p0_be} = '0;
    {p1_req, p1_wr, p1_addr, p1_wdata, p1_be} = '0;
    rst_n = 1'b1;
    #2;
    // Reset with a port-0 read already pending: no grant until the sweep ends.
    p0_req = 1'b1; p0_addr = 7'd0; p0_wdata = 32'h1357_9BDF;
    do_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    sweep(128);
    @(negedge clk);
    chk("t1_first_run", {init_done, p0_gnt, p1_gnt}, 3'b110);
    @(posedge clk); #1 p0_req = 1'b0;
    // Partial byte write then read-back.
    acc(1'b0, 1'b1, 7'd5, 32'hA5A5_1234, 4'b0101);
    acc(1'b0, 1'b0, 7'd5, 32'h0, 4'hF);
    idle(2);
    chk("t2_q0_empty", 32'(q0.size()), 32'd0);
    // Both ports requesting continuously: 7 port-0 wins then one port-1 win.
    p0_req = 1'b1; p0_wr = 1'b0; p0_addr = 7'd5; p0_wdata = 32'h1111_2222;
    p1_req = 1'b1; p1_wr = 1'b0; p1_addr = 7'd5; p1_wdata = 32'h3333_4444;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      chk("t3_arb", {p1_gnt, p0_gnt}, (c % 8 == 7) ? 2'b10 : 2'b01);
      @(posedge clk); #1;
    end
    p0_req = 1'b0; p1_req = 1'b0;
    idle(2);
    // Port-1 back-to-back read stream.
    for (int i = 1; i <= 3; i++) acc(1'b0, 1'b1, 7'(i), 32'hC0DE_0000 + 32'(i * 17), 4'hF);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        p1_req = 1'b1; p1_wr = 1'b0; p1_addr = 7'(i + 1); p1_wdata = $urandom;
      end else p1_req = 1'b0;
      @(negedge clk);
      chk("t4_gnt", p1_gnt, i < 3);
      chk("t4_rvld", {p1_rvld, p0_rvld}, (i >= 1 && i <= 3) ? 2'b10 : 2'b00);
      @(posedge clk); #1;
    end
    // Write with no byte enables changes nothing.
    acc(1'b0, 1'b1, 7'd9, 32'hFFFF_FFFF, 4'b0000);
    acc(1'b0, 1'b0, 7'd9, 32'h0, 4'h0);
    acc(1'b1, 1'b1, 7'd20, 32'hDEAD_BEEF, 4'b1010);
    acc(1'b1, 1'b0, 7'd20, 32'h0, 4'h0);
    idle(2);
    chk("t5_q0_empty", 32'(q0.size()), 32'd0);
    chk("t5_q1_empty", 32'(q1.size()), 32'd0);
    // Reset in the middle of the sweep.
    do_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    sweep(60);
    @(posedge clk); #1;
    p0_req = 1'b1; p1_req = 1'b1;
    do_reset();
    @(posedge clk); #1;
    p0_req = 1'b0; p1_req = 1'b0; rst_n = 1'b1;
    sweep(128);
    @(negedge clk);
    chk("t6_done", init_done, 1'b1);
    // Reset one cycle after a read grant drops the pending rvld.
    @(posedge clk); #1;
    p0_req = 1'b1; p0_wr = 1'b0; p0_addr = 7'd3;
    @(negedge clk);
    chk("t6_gnt", p0_gnt, 1'b1);
    @(posedge clk); #1;
    p0_req = 1'b0;
    do_reset();
    @(negedge clk);
    chk("t6_rvld_drop", {p0_rvld, p1_rvld}, 2'b00);
    @(posedge clk); #1 rst_n = 1'b1;
    sweep(128);
    @(posedge clk); #1;
    acc(1'b0, 1'b0, 7'd3, 32'h0, 4'h0);
    acc(1'b1, 1'b0, 7'd127, 32'h0, 4'h0);
    idle(3);
    chk("end_q0_empty", 32'(q0.size()), 32'd0);
    chk("end_q1_empty", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
